// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: saturating counter arithmetic and
// counter reset/allocation values, usable for any counter width up to CTR_W_MAX.
package bp_pkg;

  localparam int CTR_W_MAX = 16;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  // Reset value: weakly not-taken, 2^(w-1)-1.
  function automatic ctr_t ctr_init(input int w);
    return ctr_t'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  // Allocation value: weakly taken, 2^(w-1).
  function automatic ctr_t ctr_alloc(input int w);
    return ctr_t'(32'd1 << (w - 1));
  endfunction

  function automatic ctr_t sat_inc(input ctr_t ctr, input int w);
    ctr_t top;
    top = ctr_t'((32'd1 << w) - 32'd1);
    return (ctr >= top) ? ctr : ctr + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t ctr, input int w);
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one synchronous
// read-modify-write training port that applies the counter/target update rules.
module bp_table
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CTR_W = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int TAG_W = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rdIdx,
  output logic             rdValid,
  output logic [TAG_W-1:0] rdTag,
  output logic [XLEN-1:0]  rdTarget,
  output logic [CTR_W-1:0] rdCtr,
  input  logic             updEn,
  input  logic [IDX_W-1:0] updIdx,
  input  logic [TAG_W-1:0] updTag,
  input  logic             updTaken,
  input  logic [XLEN-1:0]  updTarget
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc(CTR_W));

  entry_t entries [DEPTH];
  entry_t curEntry;
  entry_t nxtEntry;
  logic   updHit;

  assign rdValid  = entries[rdIdx].valid;
  assign rdTag    = entries[rdIdx].tag;
  assign rdTarget = entries[rdIdx].target;
  assign rdCtr    = entries[rdIdx].ctr;

  // Training: hits adjust the counter (and refresh the target when taken);
  // a taken miss claims the slot, a not-taken miss leaves it alone.
  always_comb begin
    curEntry = entries[updIdx];
    nxtEntry = curEntry;
    updHit   = curEntry.valid && (curEntry.tag == updTag);
    if (updHit) begin
      if (updTaken) begin
        nxtEntry.ctr    = CTR_W'(sat_inc(CTR_W_MAX'(curEntry.ctr), CTR_W));
        nxtEntry.target = updTarget;
      end else begin
        nxtEntry.ctr = CTR_W'(sat_dec(CTR_W_MAX'(curEntry.ctr), CTR_W));
      end
    end else if (updTaken) begin
      nxtEntry = '{valid: 1'b1, tag: updTag, target: updTarget, ctr: CTR_ALLOC};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
      end
    end else if (updEn) begin
      entries[updIdx] <= nxtEntry;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: combinational BTB lookup at fetch, a decode-stage
// copy of the prediction, resolve/mispredict logic and saturating statistics.
module branch_predictor #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              if_valid,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_resolve,
  input  logic              id_taken,
  input  logic [XLEN-1:0]   id_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  function automatic logic [STAT_W-1:0] statInc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [IDX_W-1:0] ifIdx;
  logic [TAG_W-1:0] ifTag;
  logic             rdValid;
  logic [TAG_W-1:0] rdTag;
  logic [XLEN-1:0]  rdTarget;
  logic [CTR_W-1:0] rdCtr;
  logic             ifHit;

  logic             idValid_p1;
  logic [XLEN-1:0]  idPc_p1;
  logic             idPredTaken_p1;
  logic [XLEN-1:0]  idPredTarget_p1;
  logic             resolveActive;
  logic             updEn;

  assign ifIdx = if_pc[IDX_W+1:2];
  assign ifTag = if_pc[XLEN-1:IDX_W+2];

  bp_table #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CTR_W (CTR_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .rdIdx     (ifIdx),
    .rdValid   (rdValid),
    .rdTag     (rdTag),
    .rdTarget  (rdTarget),
    .rdCtr     (rdCtr),
    .updEn     (updEn),
    .updIdx    (idPc_p1[IDX_W+1:2]),
    .updTag    (idPc_p1[XLEN-1:IDX_W+2]),
    .updTaken  (id_taken),
    .updTarget (id_target)
  );

  // Fetch stage (p0): lookup
  assign ifHit       = rdValid && (rdTag == ifTag);
  assign pred_taken  = if_valid && ifHit && rdCtr[CTR_W-1];
  assign pred_target = pred_taken ? rdTarget : if_pc + PC_STEP;

  // Decode stage (p1): held copy of the fetch prediction
  always_ff @(posedge clk) begin
    if (reset) begin
      idValid_p1      <= 1'b0;
      idPc_p1         <= '0;
      idPredTaken_p1  <= 1'b0;
      idPredTarget_p1 <= '0;
    end else if (flush || mispredict) begin
      idValid_p1 <= 1'b0;
    end else if (!stall) begin
      idValid_p1      <= if_valid;
      idPc_p1         <= if_pc;
      idPredTaken_p1  <= pred_taken;
      idPredTarget_p1 <= pred_target;
    end
  end

  assign resolveActive = idValid_p1 && !stall;
  assign updEn         = resolveActive && id_resolve;

  // A predicted-taken slot that turns out not to be a branch must still redirect.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (resolveActive) begin
      if (id_resolve) begin
        mispredict = (id_taken != idPredTaken_p1) ||
                     (id_taken && (idPredTarget_p1 != id_target));
      end else begin
        mispredict = idPredTaken_p1;
      end
    end
    if (mispredict) begin
      redirect_pc = (id_resolve && id_taken) ? id_target : idPc_p1 + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (if_valid && !stall) stat_lookups <= statInc(stat_lookups);
      if (mispredict) stat_mispredicts <= statInc(stat_mispredicts);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic, all
// compared each cycle against a behavioural BTB model kept in plain arrays.
module tb_branch_predictor;

  localparam int DEPTH = 16;
  localparam int CTR_MAX = 3;
  localparam int CTR_TAKEN_MIN = 2;

  logic        clk = 1'b0;
  logic        reset, if_valid, stall, flush, id_resolve, id_taken;
  logic [31:0] if_pc, id_target;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] stat_lookups, stat_mispredicts;
  logic        sPredTaken, sMisp;
  logic [31:0] sPredTarget, sRedirect;
  logic [3:0]  sLook, sMispCnt;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .DEPTH(16), .CTR_W(2), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_valid(if_valid),
    .pred_taken(pred_taken), .pred_target(pred_target), .stall(stall), .flush(flush),
    .id_resolve(id_resolve), .id_taken(id_taken), .id_target(id_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.XLEN(32), .DEPTH(16), .CTR_W(2), .STAT_W(4)) dutSat (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_valid(if_valid),
    .pred_taken(sPredTaken), .pred_target(sPredTarget), .stall(stall), .flush(flush),
    .id_resolve(id_resolve), .id_taken(id_taken), .id_target(id_target),
    .mispredict(sMisp), .redirect_pc(sRedirect),
    .stat_lookups(sLook), .stat_mispredicts(sMispCnt)
  );

  // Reference model state
  bit          mValid [DEPTH];
  logic [31:0] mTag [DEPTH];
  logic [31:0] mTarget [DEPTH];
  int          mCtr [DEPTH];
  logic        dValid, dPredT;
  logic [31:0] dPc, dPredTgt;
  int          mLook, mMisp;
  logic        eTaken, eMisp;
  logic [31:0] eTgt, eRed;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic int satv(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 1'b0; mTag[i] = '0; mTarget[i] = '0; mCtr[i] = 1;
    end
    dValid = 1'b0; dPredT = 1'b0; dPc = '0; dPredTgt = '0;
    mLook = 0; mMisp = 0;
  endtask

  task automatic drive(input logic rst, input logic ifv, input logic [31:0] pc,
                       input logic st, input logic fl, input logic res,
                       input logic tk, input logic [31:0] tgt);
    int ix;
    reset = rst; if_valid = ifv; if_pc = pc; stall = st; flush = fl;
    id_resolve = res; id_taken = tk; id_target = tgt;
    @(negedge clk);
    ix = idxOf(pc);
    eTaken = ifv && mValid[ix] && (mTag[ix] == tagOf(pc)) && (mCtr[ix] >= CTR_TAKEN_MIN);
    eTgt = eTaken ? mTarget[ix] : pc + 32'd4;
    eMisp = 1'b0;
    if (dValid && !st) eMisp = res ? ((tk != dPredT) || (tk && (dPredTgt != tgt))) : dPredT;
    eRed = !eMisp ? 32'd0 : (res && tk) ? tgt : dPc + 32'd4;
    chk("pred_taken", 32'(pred_taken), 32'(eTaken));
    chk("pred_target", pred_target, eTgt);
    chk("mispredict", 32'(mispredict), 32'(eMisp));
    chk("redirect_pc", redirect_pc, eRed);
    chk("stat_lookups", 32'(stat_lookups), 32'(satv(mLook, 16)));
    chk("stat_mispredicts", 32'(stat_mispredicts), 32'(satv(mMisp, 16)));
    chk("sat_lookups", 32'(sLook), 32'(satv(mLook, 4)));
    chk("sat_mispredicts", 32'(sMispCnt), 32'(satv(mMisp, 4)));
    chk("sat_mispredict", 32'(sMisp), 32'(eMisp));
  endtask

  task automatic tick();
    int ux;
    if (reset) begin
      modelReset();
    end else begin
      if (dValid && id_resolve && !stall) begin
        ux = idxOf(dPc);
        if (mValid[ux] && mTag[ux] == tagOf(dPc)) begin
          if (id_taken) begin
            mCtr[ux] = (mCtr[ux] < CTR_MAX) ? mCtr[ux] + 1 : CTR_MAX;
            mTarget[ux] = id_target;
          end else begin
            mCtr[ux] = (mCtr[ux] > 0) ? mCtr[ux] - 1 : 0;
          end
        end else if (id_taken) begin
          mValid[ux] = 1'b1; mTag[ux] = tagOf(dPc); mTarget[ux] = id_target; mCtr[ux] = 2;
        end
      end
      if (if_valid && !stall) mLook++;
      if (eMisp) mMisp++;
      if (flush || eMisp) dValid = 1'b0;
      else if (!stall) begin
        dValid = if_valid; dPc = if_pc; dPredT = eTaken; dPredTgt = eTgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic ifv, input logic [31:0] pc,
                      input logic st, input logic fl, input logic res,
                      input logic tk, input logic [31:0] tgt);
    drive(rst, ifv, pc, st, fl, res, tk, tgt);
    tick();
  endtask

  logic [31:0] pcPool [7];
  logic [31:0] tgtPool [4];

  initial begin
    pcPool = '{32'h100, 32'h140, 32'h180, 32'h1c0, 32'h104, 32'h200, 32'hFFFF_FFFC};
    tgtPool = '{32'h200, 32'h300, 32'h400, 32'h0};
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; stall = 1'b0; flush = 1'b0;
    id_resolve = 1'b0; id_taken = 1'b0; id_target = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    modelReset();

    // Reset state and first lookups
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("rst_lookups", 32'(stat_lookups), 0);
    chk("rst_mispredicts", 32'(stat_mispredicts), 0);
    chk("rst_pred_target", pred_target, 32'h104);
    tick();
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    chk("wrap_pred_target", pred_target, 32'h0);
    tick();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("fetch100_taken", 32'(pred_taken), 0);
    chk("fetch100_target", pred_target, 32'h104);
    tick();
    drive(0, 1, 32'h104, 0, 0, 1, 0, 32'h200);
    chk("nt_resolve_misp", 32'(mispredict), 0);
    tick();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("nt_no_alloc", 32'(pred_taken), 0);
    tick();
    // Taken resolve allocates, next fetch predicts taken
    drive(0, 1, 32'h104, 0, 0, 1, 1, 32'h200);
    chk("taken_misp", 32'(mispredict), 1);
    chk("taken_redirect", redirect_pc, 32'h200);
    tick();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("alloc_pred_taken", 32'(pred_taken), 1);
    chk("alloc_pred_target", pred_target, 32'h200);
    tick();
    drive(0, 1, 32'h108, 0, 0, 1, 0, 0);
    chk("nt1_misp", 32'(mispredict), 1);
    chk("nt1_redirect", redirect_pc, 32'h104);
    tick();
    step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h104, 0, 0, 1, 0, 0);
    chk("nt2_misp", 32'(mispredict), 0);
    tick();
    // Aliasing: 0x140 evicts 0x100 at index 0
    step(0, 1, 32'h140, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h144, 0, 0, 1, 1, 32'h300);
    chk("alias_alloc_misp", 32'(mispredict), 1);
    tick();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("alias_miss", 32'(pred_taken), 0);
    tick();
    drive(0, 1, 32'h140, 0, 0, 0, 0, 0);
    chk("alias_hit_target", pred_target, 32'h300);
    tick();
    // Stall with a resolving branch: a single update on release
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h180, 1, 0, 1, 0, 0);
      chk("stall_no_misp", 32'(mispredict), 0);
      tick();
    end
    drive(0, 1, 32'h180, 0, 0, 1, 0, 0);
    chk("stall_release_redirect", redirect_pc, 32'h144);
    tick();
    step(0, 1, 32'h140, 0, 0, 0, 0, 0);
    step(0, 1, 32'h184, 0, 0, 1, 1, 32'h300);
    drive(0, 1, 32'h140, 0, 0, 0, 0, 0);
    chk("single_update_ctr", 32'(pred_taken), 1);
    tick();
    // flush beats stall
    step(0, 1, 32'h1c0, 1, 1, 0, 0, 0);
    drive(0, 1, 32'h1c4, 0, 0, 0, 0, 0);
    chk("flush_stall_invalid", 32'(mispredict), 0);
    tick();
    // Drive twenty guaranteed mispredicts
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'h2000 + 32'(i) * 32'd4, 0, 0, 0, 0, 0);
      step(0, 1, 32'h3000, 0, 0, 1, 1, 32'h8000 + 32'(i) * 32'd16);
    end
    drive(0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("sat_misp_15", 32'(sMispCnt), 32'd15);
    tick();
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 3) != 0),
           pcPool[$urandom_range(0, 6)], logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), tgtPool[$urandom_range(0, 3)]);
    end
    // Mid-run reset clears table and counters
    step(0, 1, 32'h140, 0, 0, 1, 1, 32'h300);
    step(1, 1, 32'h140, 1, 1, 1, 1, 32'h300);
    drive(0, 1, 32'h140, 0, 0, 0, 0, 0);
    chk("reset_lookups", 32'(stat_lookups), 0);
    chk("reset_mispredicts", 32'(stat_mispredicts), 0);
    chk("reset_pred_taken", 32'(pred_taken), 0);
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
